// File: rtl/branch_predictor_btb_if.sv
// Fetch-side bundle between the IF/resolve pipeline and the branch target buffer:
// combinational lookup, resolved-outcome update, table clear and perf counters.
interface branch_predictor_btb_if #(
   parameter int ADDR_W = 32,
   parameter int PERF_W = 16
);
   logic [ADDR_W-1:0] lookup_pc;
   logic              lookup_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_next_pc;
   logic              update_valid;
   logic [ADDR_W-1:0] update_pc;
   logic              update_taken;
   logic [ADDR_W-1:0] update_target;
   logic              clear;
   logic [PERF_W-1:0] update_count;
   logic [PERF_W-1:0] mispredict_count;

   modport master (
      output lookup_pc, update_valid, update_pc, update_taken, update_target, clear,
      input  lookup_hit, pred_taken, pred_next_pc, update_count, mispredict_count
   );

   modport slave (
      input  lookup_pc, update_valid, update_pc, update_taken, update_target, clear,
      output lookup_hit, pred_taken, pred_next_pc, update_count, mispredict_count
   );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating direction counters; zero-latency lookup from
// registered table state, updates and perf counters applied at the rising edge.
module branch_predictor_btb #(
   parameter int ADDR_W   = 32,
   parameter int DEPTH    = 16,
   parameter int CTR_BITS = 2,
   parameter int PERF_W   = 16
) (
   input logic Clk,
   input logic Reset,
   branch_predictor_btb_if.slave bus
);
   localparam int IDX   = $clog2(DEPTH);
   localparam int TAG_W = ADDR_W - IDX - 2;

   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
   localparam logic [PERF_W-1:0]   PERF_MAX = '1;

   function automatic logic [CTR_BITS-1:0] ctrInc(input logic [CTR_BITS-1:0] c);
      return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
   endfunction

   function automatic logic [CTR_BITS-1:0] ctrDec(input logic [CTR_BITS-1:0] c);
      return (c == '0) ? c : c - CTR_BITS'(1);
   endfunction

   function automatic logic [PERF_W-1:0] perfInc(input logic [PERF_W-1:0] c);
      return (c == PERF_MAX) ? c : c + PERF_W'(1);
   endfunction

   logic                validQ  [DEPTH];
   logic [TAG_W-1:0]    tagQ    [DEPTH];
   logic [ADDR_W-1:0]   targetQ [DEPTH];
   logic [CTR_BITS-1:0] ctrQ    [DEPTH];
   logic [PERF_W-1:0]   updateCountQ;
   logic [PERF_W-1:0]   mispredictCountQ;

   logic [IDX-1:0]   lkIdx;
   logic [TAG_W-1:0] lkTag;
   logic             lkHit;
   logic             lkTaken;
   logic [IDX-1:0]   upIdx;
   logic [TAG_W-1:0] upTag;
   logic             upHit;
   logic             upPredTaken;
   logic             upMispredict;
   logic             unusedPcBits;

   // Instructions are word aligned, so the low two PC bits carry no information.
   assign unusedPcBits = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};

   always_comb begin
      lkIdx   = bus.lookup_pc[IDX+1:2];
      lkTag   = bus.lookup_pc[ADDR_W-1:IDX+2];
      lkHit   = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
      lkTaken = lkHit && ctrQ[lkIdx][CTR_BITS-1];
   end

   assign bus.lookup_hit       = lkHit;
   assign bus.pred_taken       = lkTaken;
   assign bus.pred_next_pc     = lkTaken ? targetQ[lkIdx] : bus.lookup_pc + ADDR_W'(4);
   assign bus.update_count     = updateCountQ;
   assign bus.mispredict_count = mispredictCountQ;

   // Re-run the lookup rules on the resolving PC against pre-edge state.
   always_comb begin
      upIdx        = bus.update_pc[IDX+1:2];
      upTag        = bus.update_pc[ADDR_W-1:IDX+2];
      upHit        = validQ[upIdx] && (tagQ[upIdx] == upTag);
      upPredTaken  = upHit && ctrQ[upIdx][CTR_BITS-1];
      upMispredict = (upPredTaken != bus.update_taken) ||
                     (upPredTaken && bus.update_taken && (targetQ[upIdx] != bus.update_target));
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            validQ[i]  <= 1'b0;
            tagQ[i]    <= '0;
            targetQ[i] <= '0;
            ctrQ[i]    <= CTR_WNT;
         end
         updateCountQ     <= '0;
         mispredictCountQ <= '0;
      end else if (bus.clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            validQ[i] <= 1'b0;
            ctrQ[i]   <= CTR_WNT;
         end
      end else if (bus.update_valid) begin
         updateCountQ <= perfInc(updateCountQ);
         if (upMispredict) mispredictCountQ <= perfInc(mispredictCountQ);
         if (upHit) begin
            if (bus.update_taken) begin
               ctrQ[upIdx]    <= ctrInc(ctrQ[upIdx]);
               targetQ[upIdx] <= bus.update_target;
            end else begin
               ctrQ[upIdx] <= ctrDec(ctrQ[upIdx]);
            end
         end else if (bus.update_taken) begin
            validQ[upIdx]  <= 1'b1;
            tagQ[upIdx]    <= upTag;
            targetQ[upIdx] <= bus.update_target;
            ctrQ[upIdx]    <= CTR_WT;
         end
      end
   end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: cold lookup, allocation, counter
// saturation, aliasing, same-cycle behaviour, clear and asynchronous reset.
module tb_branch_predictor_btb;
   logic Clk = 1'b0;
   logic Reset = 1'b1;
   int   assertCount = 0;
   int   failCount = 0;

   branch_predictor_btb_if #(.ADDR_W(32), .PERF_W(16)) bus ();

   branch_predictor_btb #(.ADDR_W(32), .DEPTH(16), .CTR_BITS(2), .PERF_W(16)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic expHit,
                         input logic expTaken, input logic [31:0] expNext);
      bus.lookup_pc = pc;
      #1;
      checkVal({tag, ".hit"},   32'(bus.lookup_hit), 32'(expHit));
      checkVal({tag, ".taken"}, 32'(bus.pred_taken), 32'(expTaken));
      checkVal({tag, ".next"},  bus.pred_next_pc,    expNext);
   endtask

   task automatic counts(input string tag, input int expUpd, input int expMis);
      checkVal({tag, ".updCnt"}, 32'(bus.update_count),     32'(expUpd));
      checkVal({tag, ".misCnt"}, 32'(bus.mispredict_count), 32'(expMis));
   endtask

   task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] target);
      bus.update_valid  = 1'b1;
      bus.update_pc     = pc;
      bus.update_taken  = taken;
      bus.update_target = target;
      tick();
      bus.update_valid  = 1'b0;
   endtask

   initial begin
      bus.lookup_pc     = 32'h40;
      bus.update_valid  = 1'b0;
      bus.update_pc     = '0;
      bus.update_taken  = 1'b0;
      bus.update_target = '0;
      bus.clear         = 1'b0;

      // Cold lookup under reset and after release
      #2;
      lookup("rst", 32'h40, 1'b0, 1'b0, 32'h44);
      counts("rst", 0, 0);
      tick();
      Reset = 1'b0;
      tick();
      lookup("cold", 32'h40, 1'b0, 1'b0, 32'h44);
      counts("cold", 0, 0);

      // Allocate on a taken miss
      update(32'h40, 1'b1, 32'h100);
      lookup("alloc", 32'h40, 1'b1, 1'b1, 32'h100);
      counts("alloc", 1, 1);

      // Down-count 2->1->0->0
      update(32'h40, 1'b0, 32'h0);
      update(32'h40, 1'b0, 32'h0);
      update(32'h40, 1'b0, 32'h0);
      lookup("floor", 32'h40, 1'b1, 1'b0, 32'h44);
      counts("floor", 4, 2);

      // Up-count 0->1->2->3->3, then two not-taken steps back to 1
      for (int i = 0; i < 4; i++) update(32'h40, 1'b1, 32'h100);
      lookup("sat", 32'h40, 1'b1, 1'b1, 32'h100);
      counts("sat", 8, 4);
      update(32'h40, 1'b0, 32'h0);
      lookup("sat-1", 32'h40, 1'b1, 1'b1, 32'h100);
      update(32'h40, 1'b0, 32'h0);
      lookup("sat-2", 32'h40, 1'b1, 1'b0, 32'h44);
      counts("sat-2", 10, 6);

      // Alias replacement at index 0
      update(32'h80, 1'b1, 32'h200);
      lookup("alias80", 32'h80, 1'b1, 1'b1, 32'h200);
      lookup("alias40", 32'h40, 1'b0, 1'b0, 32'h44);
      counts("alias", 11, 7);
      update(32'h40, 1'b0, 32'h0);
      lookup("aliasNt", 32'h80, 1'b1, 1'b1, 32'h200);
      counts("aliasNt", 12, 7);

      // Lookup during own update sees the old entry
      bus.update_valid  = 1'b1;
      bus.update_pc     = 32'h80;
      bus.update_taken  = 1'b1;
      bus.update_target = 32'h300;
      lookup("same.pre", 32'h80, 1'b1, 1'b1, 32'h200);
      tick();
      bus.update_valid = 1'b0;
      lookup("same.post", 32'h80, 1'b1, 1'b1, 32'h300);
      counts("same", 13, 8);

      // Clear wins over a same-cycle update; counters hold
      bus.clear = 1'b1;
      update(32'h40, 1'b1, 32'h100);
      bus.clear = 1'b0;
      lookup("clr80", 32'h80, 1'b0, 1'b0, 32'h84);
      lookup("clr40", 32'h40, 1'b0, 1'b0, 32'h44);
      counts("clr", 13, 8);

      // Asynchronous reset between clock edges
      update(32'h40, 1'b1, 32'h100);
      lookup("pre-arst", 32'h40, 1'b1, 1'b1, 32'h100);
      counts("pre-arst", 14, 9);
      Reset = 1'b1;
      lookup("arst", 32'h40, 1'b0, 1'b0, 32'h44);
      counts("arst", 0, 0);
      #1;
      Reset = 1'b0;
      tick();
      lookup("recold", 32'h40, 1'b0, 1'b0, 32'h44);
      counts("recold", 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule
